madd_stream: RTL and testbench
==============================

Name: madd_stream

Overview:
- Streaming, time-multiplexed signed matrix adder/subtractor for ADDER_NUM x DIMENTION matrices. Consumes LANES elements per beat from two operand streams and emits LANES results per beat.
- Replaces fully-parallel matrix addition where the flat bus width is prohibitive, e.g. residual adds between transformer layers fed from SRAM.
- Adds valid/ready flow control, row/matrix framing, wrap/saturate and add/subtract modes, and per-beat overflow reporting.

Parameters:
- ADDER_NUM, 128: matrix rows.
- DIMENTION, 768: matrix columns. Must be divisible by LANES.
- WIDTH_ADDEND, 8: signed operand element width.
- WIDTH_SUM, WIDTH_ADDEND: signed result element width. Must be >= WIDTH_ADDEND.
- LANES, 32: elements per beat.
- Derived, not a port: BEATS_ROW = DIMENTION/LANES. Total beats per matrix = ADDER_NUM*BEATS_ROW.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst_n, in, 1: synchronous active-low reset.
- abort, in, 1: synchronous frame abort.
- cfg_sat, in, 1: 1 = saturate, 0 = wrap.
- cfg_sub, in, 1: 1 = addend1-addend2, 0 = addend1+addend2.
- in_valid, in, 1: both operand beats present.
- in_ready, out, 1: beat accepted when in_valid&&in_ready.
- addend1, in, LANES*WIDTH_ADDEND: packed signed elements, lane k at [k*W +: W].
- addend2, in, LANES*WIDTH_ADDEND: same packing as addend1.
- out_valid, out, 1: result beat valid.
- out_ready, in, 1: downstream accepts result.
- sum, out, LANES*WIDTH_SUM: packed signed results, same lane order.
- out_ovf, out, 1: OR over lanes of overflow in this beat.
- out_last_row, out, 1: beat is the final beat of a row.
- out_last, out, 1: beat is the final beat of the matrix.
- busy, out, 1: high while a matrix is partially consumed.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - out_valid, sum, out_ovf, out_last_row, out_last, busy = 0.
  - Column/row counters = 0.
  - Latched mode = add/wrap.
- in_ready is asserted in reset.
- Pipeline is a single output register:
  - in_ready = !out_valid || out_ready.
  - Latency is 1 cycle from an accepted beat to out_valid.
  - Full throughput of 1 beat/cycle when out_ready is held high.
- Output hold: while out_valid && !out_ready, sum, out_ovf, out_last_row and out_last hold stable and in_ready = 0.
- Counters advance only on an accepted beat:
  - col_cnt runs 0..BEATS_ROW-1.
  - On wrap, row_cnt runs 0..ADDER_NUM-1.
  - Both wrap to 0 after the last beat, so back-to-back matrices need no gap.
- Framing flags are registered with their beat:
  - out_last_row = (col_cnt==BEATS_ROW-1).
  - out_last = out_last_row && (row_cnt==ADDER_NUM-1).
- Mode latch:
  - cfg_sat and cfg_sub are sampled on the first beat of a matrix (both counters 0).
  - They are held for the whole matrix; cfg changes mid-matrix are ignored.
- busy:
  - Set on acceptance of the first beat.
  - Cleared on acceptance of the last beat. A 1-beat matrix therefore never raises busy.
- Arithmetic per lane:
  - Sign-extend both operands to WIDTH_ADDEND+1 bits.
  - Compute a ± b exactly.
  - If WIDTH_SUM > WIDTH_ADDEND: sign-extend to WIDTH_SUM. out_ovf is always 0.
  - If WIDTH_SUM == WIDTH_ADDEND: lane overflows when the exact result is outside [-2^(W-1), 2^(W-1)-1].
    - Wrap mode: output the low W bits.
    - Saturate mode: clamp to the nearest bound.
    - out_ovf reports overflow in either mode.
- abort=1 at a clk edge:
  - Counters := 0, busy := 0, out_valid := 0.
  - Any pending output is dropped and the input beat that cycle is not accepted.
  - Abort has priority over acceptance, and rst_n has priority over abort.
- Reset mid-matrix behaves like abort plus clearing the mode latch. The next accepted beat is row 0, column 0.

Test Plan:
- Config LANES=4, DIMENTION=8, ADDER_NUM=2, W=8. Stream 4 beats with out_ready=1 and add/wrap; a=[1,2,3,4], b=[10,20,30,40] each beat.
  - Required: sum=[11,22,33,44], 1-cycle latency, out_last_row on beats 2 and 4, out_last on beat 4 only, busy high for cycles 1-3.
- Overflow, same config: a=[127,-128,100,-1], b=[1,-1,100,1].
  - Wrap: sum=[-128,127,-56,0], out_ovf=1.
  - Saturate: sum=[127,-128,127,0], out_ovf=1.
- Subtract with cfg_sub=1, cfg_sat=1: a=[-128,5,0,0], b=[1,7,-128,0] -> sum=[-128,-2,127,0].
- Backpressure: hold out_ready=0 for 3 cycles after the first beat.
  - Required: in_ready=0, sum stable, no counter advance.
  - On release, remaining beats emerge in order with correct framing.
- Mode latch: toggle cfg_sat at beat 2 of a matrix.
  - Required: the matrix keeps its initial mode; the next matrix uses the new value.
- Abort at beat 3 and reset at beat 2.
  - Required: out_valid=0 and busy=0 next cycle.
  - A fresh 4-beat matrix is framed from beat 1, with out_last on its 4th beat.
- WIDTH_SUM=9: 127+127 -> 254, -128+-128 -> -256, out_ovf=0.

Source files
------------

// File: rtl/madd_stream.sv
// Streaming signed matrix adder/subtractor: LANES elements per beat, one output
// register stage, row/matrix framing, per-matrix latched wrap/saturate and add/sub mode.
module madd_stream #(
  parameter int unsigned ADDER_NUM    = 128,
  parameter int unsigned DIMENTION    = 768,
  parameter int unsigned WIDTH_ADDEND = 8,
  parameter int unsigned WIDTH_SUM    = WIDTH_ADDEND,
  parameter int unsigned LANES        = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          abort,
  input  logic                          cfg_sat,
  input  logic                          cfg_sub,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*WIDTH_ADDEND-1:0] addend1,
  input  logic [LANES*WIDTH_ADDEND-1:0] addend2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*WIDTH_SUM-1:0]    sum,
  output logic                          out_ovf,
  output logic                          out_last_row,
  output logic                          out_last,
  output logic                          busy
);

  localparam int unsigned BEATS_ROW = DIMENTION / LANES;
  localparam int unsigned CW        = (BEATS_ROW > 1) ? $clog2(BEATS_ROW) : 1;
  localparam int unsigned RW        = (ADDER_NUM > 1) ? $clog2(ADDER_NUM) : 1;
  localparam int unsigned WE        = WIDTH_ADDEND + 1;
  localparam int unsigned WS        = LANES * WIDTH_SUM;

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_sat;
  logic             r_sub;
  logic             r_out_valid;
  logic [WS-1:0]    r_sum;
  logic             r_ovf;
  logic             r_last_row;
  logic             r_last;
  logic             r_busy;

  logic             w_accept;
  logic             w_first;
  logic             w_sat;
  logic             w_sub;
  logic             w_col_last;
  logic             w_row_last;
  logic [WS-1:0]    w_sum;
  logic [LANES-1:0] w_lane_ovf;

  assign in_ready   = !rst_n || !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_first    = (r_col == '0) && (r_row == '0);
  assign w_col_last = (r_col == CW'(BEATS_ROW - 1));
  assign w_row_last = (r_row == RW'(ADDER_NUM - 1));

  // First beat of a matrix uses the live config; later beats use the latched copy.
  assign w_sat = w_first ? cfg_sat : r_sat;
  assign w_sub = w_first ? cfg_sub : r_sub;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [WE-1:0] w_a;
    logic signed [WE-1:0] w_b;
    logic signed [WE-1:0] w_x;

    assign w_a = WE'($signed(addend1[k*WIDTH_ADDEND +: WIDTH_ADDEND]));
    assign w_b = WE'($signed(addend2[k*WIDTH_ADDEND +: WIDTH_ADDEND]));
    assign w_x = w_sub ? (w_a - w_b) : (w_a + w_b);

    if (WIDTH_SUM > WIDTH_ADDEND) begin : g_wide
      assign w_sum[k*WIDTH_SUM +: WIDTH_SUM] = WIDTH_SUM'(w_x);
      assign w_lane_ovf[k]                   = 1'b0;
    end else begin : g_narrow
      logic w_ov;
      // Exact result leaves the W-bit range when the two top bits disagree.
      assign w_ov          = w_x[WE-1] ^ w_x[WE-2];
      assign w_lane_ovf[k] = w_ov;
      assign w_sum[k*WIDTH_SUM +: WIDTH_SUM] = (w_ov && w_sat)
          ? {w_x[WE-1], {(WIDTH_ADDEND-1){~w_x[WE-1]}}}
          : w_x[WIDTH_ADDEND-1:0];
    end
  end

  // Output register, framing counters, mode latch and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_sat       <= 1'b0;
      r_sub       <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_last_row  <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
    end else if (abort) begin
      r_col       <= '0;
      r_row       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_sum       <= w_sum;
      r_ovf       <= |w_lane_ovf;
      r_last_row  <= w_col_last;
      r_last      <= w_col_last && w_row_last;
      r_busy      <= !(w_col_last && w_row_last);
      if (w_first) begin
        r_sat <= cfg_sat;
        r_sub <= cfg_sub;
      end
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign sum          = r_sum;
  assign out_ovf      = r_ovf;
  assign out_last_row = r_last_row;
  assign out_last     = r_last;
  assign busy         = r_busy;

endmodule

// File: tb/tb_madd_stream.sv
// Bench for madd_stream (4 lanes, 2x8 matrix): scoreboard monitor plus per-scenario tasks;
// a second instance with WIDTH_SUM=9 shares all inputs.
module tb_madd_stream;
  localparam int unsigned L  = 4;
  localparam int unsigned D  = 8;
  localparam int unsigned N  = 2;
  localparam int unsigned W  = 8;
  localparam int unsigned W9 = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, abort, cfg_sat, cfg_sub, in_valid, out_ready;
  logic [L*W-1:0] addend1, addend2;
  logic           in_ready, out_valid, out_ovf, out_last_row, out_last, busy;
  logic [L*W-1:0] sum;
  logic           in_ready9, out_valid9, ovf9, last_row9, last9, busy9;
  logic [L*W9-1:0] sum9;

  madd_stream #(.ADDER_NUM(N), .DIMENTION(D), .WIDTH_ADDEND(W), .WIDTH_SUM(W), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .cfg_sat(cfg_sat), .cfg_sub(cfg_sub),
    .in_valid(in_valid), .in_ready(in_ready), .addend1(addend1), .addend2(addend2),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .out_ovf(out_ovf),
    .out_last_row(out_last_row), .out_last(out_last), .busy(busy));

  madd_stream #(.ADDER_NUM(N), .DIMENTION(D), .WIDTH_ADDEND(W), .WIDTH_SUM(W9), .LANES(L)) dut9 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .cfg_sat(cfg_sat), .cfg_sub(cfg_sub),
    .in_valid(in_valid), .in_ready(in_ready9), .addend1(addend1), .addend2(addend2),
    .out_valid(out_valid9), .out_ready(out_ready), .sum(sum9), .out_ovf(ovf9),
    .out_last_row(last_row9), .out_last(last9), .busy(busy9));

  typedef struct packed {
    logic [L*W-1:0]  s;
    logic            ovf;
    logic [L*W9-1:0] s9;
    logic            lr;
    logic            last;
  } exp_t;

  exp_t q[$];
  exp_t e_new, e_got;
  int   m_beat;
  logic m_sat, m_sub;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [L*W-1:0] pk(input int e0, input int e1, input int e2, input int e3);
    pk = {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Integer reference for one lane at result width w.
  function automatic int lane_ref(input int a, input int b, input logic sub, input logic sat,
                                  input int w, output logic ov);
    int x, hi, lo;
    x  = sub ? a - b : a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    ov = (x > hi) || (x < lo);
    if (ov && sat) x = (x > hi) ? hi : lo;
    else if (ov) begin
      x = x & ((1 << w) - 1);
      if (x > hi) x = x - (1 << w);
    end
    return x;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n || abort) begin
      q.delete();
      m_beat = 0;
      if (!rst_n) begin
        m_sat = 1'b0;
        m_sub = 1'b0;
      end
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_beat got sum=%h expected no output", sum);
        end else begin
          e_got = q.pop_front();
          if (sum !== e_got.s || out_ovf !== e_got.ovf || sum9 !== e_got.s9 || ovf9 !== 1'b0 ||
              out_last_row !== e_got.lr || out_last !== e_got.last) begin
            failures++;
            $display("FAIL sb_beat got sum=%h ovf=%b sum9=%h ovf9=%b lr=%b last=%b exp sum=%h ovf=%b sum9=%h ovf9=0 lr=%b last=%b",
                     sum, out_ovf, sum9, ovf9, out_last_row, out_last,
                     e_got.s, e_got.ovf, e_got.s9, e_got.lr, e_got.last);
          end
        end
      end
      if (in_valid && in_ready) begin
        logic ov, ov9;
        int   a, b;
        if (m_beat == 0) begin
          m_sat = cfg_sat;
          m_sub = cfg_sub;
        end
        e_new = '0;
        for (int k = 0; k < int'(L); k++) begin
          a = int'($signed(addend1[k*W +: W]));
          b = int'($signed(addend2[k*W +: W]));
          e_new.s[k*W +: W]    = 8'(lane_ref(a, b, m_sub, m_sat, 8, ov));
          e_new.s9[k*W9 +: W9] = 9'(lane_ref(a, b, m_sub, m_sat, 9, ov9));
          e_new.ovf            = e_new.ovf | ov;
        end
        e_new.lr   = (m_beat % 2) == 1;
        e_new.last = m_beat == 3;
        q.push_back(e_new);
        m_beat = (m_beat + 1) % 4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0; cfg_sat = 1'b0; cfg_sub = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; addend1 = pk(1, 2, 3, 4); addend2 = pk(5, 6, 7, 8);
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sum !== '0 || out_ovf !== 1'b0) begin failures++; $display("FAIL reset_sum got=%h/%b exp=0/0", sum, out_ovf); end
    checks++; if (out_last_row !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", out_last_row, out_last); end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1; cfg_sat = 1'b0; cfg_sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; addend1 = pk(1, 2, 3, 4); addend2 = pk(10, 20, 30, 40);
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency beat=%0d got=%b exp=1", i, out_valid); end
      checks++; if (sum !== pk(11, 22, 33, 44)) begin failures++; $display("FAIL basic_sum beat=%0d got=%h exp=%h", i, sum, pk(11, 22, 33, 44)); end
      checks++; if (busy !== 1'(i < 3)) begin failures++; $display("FAIL basic_busy beat=%0d got=%b exp=%b", i, busy, 1'(i < 3)); end
      checks++; if (out_last_row !== 1'(i % 2 == 1)) begin failures++; $display("FAIL basic_last_row beat=%0d got=%b exp=%b", i, out_last_row, 1'(i % 2 == 1)); end
      checks++; if (out_last !== 1'(i == 3)) begin failures++; $display("FAIL basic_last beat=%0d got=%b exp=%b", i, out_last, 1'(i == 3)); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [L*W-1:0] exp_s;
    for (int m = 0; m < 2; m++) begin
      cfg_sat = 1'(m);
      exp_s = (m == 1) ? pk(127, -128, 127, 0) : pk(-128, 127, -56, 0);
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1; addend1 = pk(127, -128, 100, -1); addend2 = pk(1, -1, 100, 1);
        tick();
        checks++; if (sum !== exp_s || out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_mode%0d beat=%0d got=%h/%b exp=%h/1", m, i, sum, out_ovf, exp_s); end
      end
    end
    in_valid = 1'b0; cfg_sat = 1'b0;
    tick();
  endtask

  task automatic test_sub();
    cfg_sub = 1'b1; cfg_sat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; addend1 = pk(-128, 5, 0, 0); addend2 = pk(1, 7, -128, 0);
      tick();
      checks++; if (sum !== pk(-128, -2, 127, 0) || out_ovf !== 1'b1) begin failures++; $display("FAIL sub_sat beat=%0d got=%h/%b exp=%h/1", i, sum, out_ovf, pk(-128, -2, 127, 0)); end
    end
    in_valid = 1'b0; cfg_sub = 1'b0; cfg_sat = 1'b0;
    tick();
  endtask

  task automatic test_width9();
    logic [L*W9-1:0] exp9;
    exp9 = {9'd0, 9'd0, 9'(-256), 9'd254};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; addend1 = pk(127, -128, 0, 0); addend2 = pk(127, -128, 0, 0);
      tick();
      checks++; if (sum9 !== exp9 || ovf9 !== 1'b0) begin failures++; $display("FAIL width9 beat=%0d got=%h/%b exp=%h/0", i, sum9, ovf9, exp9); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; addend1 = pk(0, 1, 2, 3); addend2 = pk(10, 20, 30, 40);
    tick();
    addend1 = pk(1, 2, 3, 4);
    for (int c = 0; c < 3; c++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || sum !== pk(10, 21, 32, 43)) begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", c, out_valid, sum, pk(10, 21, 32, 43)); end
      checks++; if (out_last_row !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bp_flags cyc=%0d got lr=%b busy=%b exp lr=0 busy=1", c, out_last_row, busy); end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      addend1 = pk(i, i + 1, i + 2, i + 3);
      tick();
      checks++; if (sum !== pk(10 + i, 21 + i, 32 + i, 43 + i) || out_last_row !== 1'(i % 2 == 1) || out_last !== 1'(i == 3)) begin
        failures++; $display("FAIL bp_release beat=%0d got=%h lr=%b last=%b exp=%h lr=%b last=%b", i, sum, out_last_row, out_last,
                             pk(10 + i, 21 + i, 32 + i, 43 + i), 1'(i % 2 == 1), 1'(i == 3));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mode_latch();
    logic [L*W-1:0] exp_s;
    cfg_sat = 1'b0;
    for (int m = 0; m < 2; m++) begin
      exp_s = (m == 0) ? pk(-128, 0, 0, 0) : pk(127, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
        if (m == 0 && i == 1) cfg_sat = 1'b1;
        in_valid = 1'b1; addend1 = pk(127, 0, 0, 0); addend2 = pk(1, 0, 0, 0);
        tick();
        checks++; if (sum !== exp_s) begin failures++; $display("FAIL mode_latch mat=%0d beat=%0d got=%h exp=%h", m, i, sum, exp_s); end
      end
    end
    in_valid = 1'b0; cfg_sat = 1'b0;
    tick();
  endtask

  task automatic test_interrupt(input logic use_reset, input int at_beat);
    for (int i = 0; i < at_beat; i++) begin
      in_valid = 1'b1; addend1 = pk(i, 0, 0, 0); addend2 = pk(1, 0, 0, 0);
      if (i == at_beat - 1) begin
        if (use_reset) rst_n = 1'b0;
        else abort = 1'b1;
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL intr_clear rst=%b got valid=%b busy=%b exp 0/0", use_reset, out_valid, busy); end
    rst_n = 1'b1; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; addend1 = pk(3, 3, 3, 3); addend2 = pk(i, i, i, i);
      tick();
      checks++; if (out_last_row !== 1'(i % 2 == 1) || out_last !== 1'(i == 3) || sum !== pk(3 + i, 3 + i, 3 + i, 3 + i)) begin
        failures++; $display("FAIL intr_refill rst=%b beat=%0d got lr=%b last=%b sum=%h exp lr=%b last=%b", use_reset, i,
                             out_last_row, out_last, sum, 1'(i % 2 == 1), 1'(i == 3));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    m_beat = 0; m_sat = 1'b0; m_sub = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_sub();
    test_width9();
    test_backpressure();
    test_mode_latch();
    test_interrupt(1'b0, 3);
    test_interrupt(1'b1, 2);
    tick(); tick();
    checks++; if (q.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d pending exp=0", q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
